// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main controller.
// Moore decode of State into datapath controls; FETCH handshake gated by MemReady.
// Opcode is latched in DECODE so later states ignore the live instruction bus.
//
// state  | meaning
// FETCH  | read instruction, PC+4 (waits on MemReady)
// DECODE | latch opcode, compute branch target
// MEMADR | effective address for lw/sw
// MEMRD  | data read (waits on MemReady)
// MEMWB  | write loaded data to rt
// MEMWR  | data write (waits on MemReady)
// EXEC   | R-type ALU operation
// RWB    | write ALU result to rd
// BRANCH | compare and conditional PC update
// JUMP   | jump target to PC
// TRAP   | unsupported opcode, one-cycle Illegal pulse
module multicycle_control (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [5:0]  Opcode,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        BranchNE,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        ALUSrcA,
  output logic [1:0]  ALUOp,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [3:0]  State,
  output logic        Illegal,
  output logic [31:0] InstCount
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  state_t     state_q;
  logic [5:0] op_q;
  logic       retire;

  assign State = state_q;

  // An instruction retires on the edge that leaves its final state.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEMWR:                          retire = MemReady;
      default:                          retire = 1'b0;
    endcase
  end

  // Sequencer, opcode latch and retired-instruction counter.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      InstCount <= 32'd0;
    end else begin
      if (retire) InstCount <= InstCount + 32'd1;
      case (state_q)
        S_FETCH:  if (MemReady) state_q <= S_DECODE;
        S_DECODE: begin
          op_q <= Opcode;
          case (Opcode)
            OP_RTYPE:       state_q <= S_EXEC;
            OP_LW, OP_SW:   state_q <= S_MEMADR;
            OP_BEQ, OP_BNE: state_q <= S_BRANCH;
            OP_J:           state_q <= S_JUMP;
            default:        state_q <= S_TRAP;
          endcase
        end
        S_MEMADR: begin
          if (op_q == OP_LW)      state_q <= S_MEMRD;
          else if (op_q == OP_SW) state_q <= S_MEMWR;
          else                    state_q <= S_FETCH;
        end
        S_MEMRD:  if (MemReady) state_q <= S_MEMWB;
        S_MEMWR:  if (MemReady) state_q <= S_FETCH;
        S_EXEC:   state_q <= S_RWB;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Moore control decode; held at zero while reset is asserted.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    Illegal     = 1'b0;
    if (RESET) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = MemReady;
          PCWrite = MemReady;
        end
        S_DECODE: ALUSrcB = 2'b11;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCSource    = 2'b01;
          PCWriteCond = 1'b1;
          BranchNE    = (op_q == OP_BNE);
        end
        S_JUMP: begin
          PCSource = 2'b10;
          PCWrite  = 1'b1;
        end
        S_TRAP:  Illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control.
// The driver walks each instruction through the state sequence implied by its
// opcode and stall counts, pushing per-cycle expectations; a negedge monitor
// pops and compares them against the DUT.
module tb_multicycle_control;

  logic        CLK;
  logic        RESET;
  logic [5:0]  Opcode;
  logic        MemReady;
  logic        PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegWrite, RegDst, ALUSrcA, Illegal;
  logic [1:0]  ALUOp, ALUSrcB, PCSource;
  logic [3:0]  State;
  logic [31:0] InstCount;

  multicycle_control dut (
    .CLK(CLK), .RESET(RESET), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .State(State), .Illegal(Illegal), .InstCount(InstCount)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  logic [17:0] dut_ctrl;
  assign dut_ctrl = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite,
                     IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA,
                     ALUOp, ALUSrcB, PCSource, Illegal};

  typedef struct {
    int          st;
    logic [17:0] ctrl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          tests  = 0;
  int          failed = 0;
  logic [31:0] model_count = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Control outputs each state must show, taken straight from the state table.
  function automatic logic [17:0] exp_ctrl(input int st, input logic mr, input logic [5:0] lop);
    logic pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rw, rdst, srca, ill;
    logic [1:0] aluop, srcb, pcsrc;
    {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rw, rdst, srca, ill} = '0;
    aluop = 2'b00; srcb = 2'b00; pcsrc = 2'b00;
    case (st)
      0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin srca = 1; aluop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; pcwc = 1; bne = (lop == 6'd5); end
      9:  begin pcsrc = 2'b10; pcw = 1; end
      10: ill = 1;
      default: ;
    endcase
    return {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rw, rdst, srca, aluop, srcb, pcsrc, ill};
  endfunction

  // Monitor: every out-of-reset cycle with a pending expectation is compared.
  always @(negedge CLK) begin
    if (RESET && sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("state", {28'd0, State}, e.st);
      chk("ctrl", {14'd0, dut_ctrl}, {14'd0, e.ctrl});
      chk("inst_count", InstCount, e.cnt);
    end
  end

  // One clock cycle: drive inputs, push the expectation, cross the edge.
  task automatic do_cycle(input int st, input logic mr, input logic [5:0] op_in,
                          input logic [5:0] lop, input bit ret);
    exp_t e;
    MemReady = mr;
    Opcode   = op_in;
    e.st   = st;
    e.ctrl = exp_ctrl(st, mr, lop);
    e.cnt  = model_count;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    if (ret) model_count = model_count + 32'd1;
  endtask

  function automatic logic [5:0] rnd6();
    return 6'($urandom);
  endfunction

  function automatic logic rnd1();
    return 1'($urandom);
  endfunction

  task automatic check_reset_zero(input string tag);
    chk({tag, "_state"}, {28'd0, State}, 32'd0);
    chk({tag, "_ctrl"}, {14'd0, dut_ctrl}, 32'd0);
    chk({tag, "_count"}, InstCount, 32'd0);
  endtask

  // Called at posedge+1 with RESET low; releases between edges and realigns.
  task automatic release_reset();
    MemReady = 1'b0;
    #2;
    RESET = 1'b1;
    #1;
    chk("release_state", {28'd0, State}, 32'd0);
    chk("release_ctrl", {14'd0, dut_ctrl}, {14'd0, exp_ctrl(0, 1'b0, 6'd0)});
    @(posedge CLK);
    #1;
    chk("first_edge_state", {28'd0, State}, 32'd0);
  endtask

  // Runs one instruction; with abort set, reset hits during a MEMRD stall.
  task automatic run_instr(input logic [5:0] op, input int fst, input int mst, input bit abort);
    for (int i = 0; i < fst; i++) do_cycle(0, 1'b0, rnd6(), op, 0);
    do_cycle(0, 1'b1, rnd6(), op, 0);
    do_cycle(1, rnd1(), op, op, 0);
    case (op)
      6'd0: begin
        do_cycle(6, rnd1(), rnd6(), op, 0);
        do_cycle(7, rnd1(), rnd6(), op, 1);
      end
      6'd35: begin
        do_cycle(2, rnd1(), rnd6(), op, 0);
        if (abort) begin
          do_cycle(3, 1'b0, rnd6(), op, 0);
          MemReady = 1'b0;
          #2;
          RESET = 1'b0;
          #1;
          check_reset_zero("abort");
          model_count = 32'd0;
          MemReady = 1'b1;
          @(posedge CLK);
          #1;
          check_reset_zero("abort_hold");
          release_reset();
          return;
        end
        for (int i = 0; i < mst; i++) do_cycle(3, 1'b0, rnd6(), op, 0);
        do_cycle(3, 1'b1, rnd6(), op, 0);
        do_cycle(4, rnd1(), rnd6(), op, 1);
      end
      6'd43: begin
        do_cycle(2, rnd1(), rnd6(), op, 0);
        for (int i = 0; i < mst; i++) do_cycle(5, 1'b0, rnd6(), op, 0);
        do_cycle(5, 1'b1, rnd6(), op, 1);
      end
      6'd4, 6'd5: do_cycle(8, rnd1(), rnd6(), op, 1);
      6'd2:       do_cycle(9, rnd1(), rnd6(), op, 1);
      default:    do_cycle(10, rnd1(), rnd6(), op, 0);
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    failed++;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] legal_ops [6];
    legal_ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2};
    RESET = 1'b0;
    MemReady = 1'b1;
    Opcode = 6'd0;
    #2;
    check_reset_zero("por");
    @(posedge CLK);
    #1;
    check_reset_zero("por_edge");
    release_reset();

    // Directed: R-type, lw with stalls, sw then bne, illegal, beq.
    run_instr(6'd0, 0, 0, 0);
    run_instr(6'd35, 0, 3, 0);
    run_instr(6'd43, 1, 2, 0);
    run_instr(6'd5, 0, 0, 0);
    run_instr(6'd63, 0, 0, 0);
    run_instr(6'd4, 2, 0, 0);

    // Reset mid-MEMRD stall.
    run_instr(6'd35, 0, 0, 1);

    // Counter wrap on a jump: preload the count just before it retires.
    do_cycle(0, 1'b1, rnd6(), 6'd2, 0);
    do_cycle(1, rnd1(), 6'd2, 6'd2, 0);
    force dut.InstCount = 32'hFFFF_FFFF;
    #1;
    release dut.InstCount;
    model_count = 32'hFFFF_FFFF;
    do_cycle(9, rnd1(), rnd6(), 6'd2, 1);
    chk("wrap_count", InstCount, 32'd0);

    // Randomized instruction mix.
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 7) == 0) op = rnd6();
      else op = legal_ops[$urandom_range(0, 5)];
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end
    run_instr(6'd0, 0, 0, 0);

    @(negedge CLK);
    #1;
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have: CLK  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have: RESET  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: Opcode  input  6  instruction[31:26] from the instruction register.
REQ-004 SHALL have: MemReady  input  1  memory completion handshake for the current access.
REQ-005 SHALL have these 1-bit outputs: PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg (1 = memory data), RegWrite, RegDst (1 = rd), ALUSrcA (1 = register A).
REQ-006 SHALL have these 2-bit outputs: ALUOp (00 add, 01 sub, 10 funct), ALUSrcB (00 B, 01 const 4, 10 signext, 11 signext<<2), PCSource (00 ALU, 01 ALUOut, 10 jump target).
REQ-007 SHALL have: State  output  4  current state encoding.
REQ-008 SHALL have: Illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-009 SHALL have: InstCount  output  32  count of retired instructions.

Function
REQ-010 SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, TRAP=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-011 SHALL drive every control output as a Moore function of State, except where MemReady gating is stated; any output not listed for a state SHALL be 0.
REQ-012 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, with IRWrite=PCWrite=MemReady, and SHALL hold while MemReady=0, advancing to DECODE on the edge where MemReady=1.
REQ-013 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00, sample Opcode, and branch on the next edge: 0->EXEC, 35 or 43->MEMADR, 4 or 5->BRANCH, 2->JUMP, any other value->TRAP.
REQ-014 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEMRD if Opcode=35 or to MEMWR if Opcode=43.
REQ-015 MEMRD SHALL drive MemRead=1, IorD=1, hold while MemReady=0, and go to MEMWB when MemReady=1.
REQ-016 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-017 MEMWR SHALL drive MemWrite=1, IorD=1, hold while MemReady=0, and go to FETCH when MemReady=1.
REQ-018 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to RWB; RWB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0, then go to FETCH.
REQ-019 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1, and BranchNE=1 only when the Opcode latched in DECODE is 5; it SHALL then go to FETCH.
REQ-020 JUMP SHALL drive PCSource=10, PCWrite=1, then go to FETCH.
REQ-021 TRAP SHALL drive Illegal=1 for exactly one cycle, then go to FETCH without retiring.
REQ-022 SHALL latch the opcode into an internal register in DECODE, and all later decisions for that instruction SHALL use the latched copy; Opcode changes after DECODE SHALL be ignored.
REQ-023 InstCount SHALL increment by 1 on each edge leaving MEMWB, RWB, BRANCH or JUMP, and on the edge leaving MEMWR with MemReady=1; it SHALL wrap from 0xFFFFFFFF to 0.
REQ-024 With MemReady held at 1, latency in cycles from FETCH entry to the next FETCH entry SHALL be: lw 5, sw 4, R-type 4, beq/bne 3, j 3, illegal 3.
REQ-025 MemReady SHALL be ignored in every state other than FETCH, MEMRD and MEMWR.

Reset
REQ-026 While RESET=0, the block SHALL force State=FETCH, InstCount=0 and the latched opcode to 0, and SHALL drive every control output and Illegal to 0, irrespective of CLK.
REQ-027 An assertion of RESET in mid-instruction, including during a MemReady stall, SHALL abort that instruction immediately with no retire count.
REQ-028 On the first rising edge after RESET returns to 1, State SHALL still be FETCH, and FETCH outputs SHALL appear once RESET is released.

Verification
REQ-029 MemReady=1, Opcode=0 -> States 0,1,6,7,0; RegWrite=1 and RegDst=1 in RWB only; InstCount=1.
REQ-030 Opcode=35, MemReady low for 3 cycles in MEMRD -> MEMRD held for 4 cycles, then MEMWB with MemtoReg=1; InstCount +1.
REQ-031 Opcode=43, then Opcode=5 -> MemWrite=1 with IorD=1 in MEMWR; BRANCH shows PCWriteCond=1, BranchNE=1, PCSource=01; InstCount +2.
REQ-032 Opcode=63 -> Illegal pulse of 1 cycle in State 10, return to FETCH, InstCount unchanged.
REQ-033 RESET driven low mid-MEMRD between clock edges -> State=0, all outputs 0 and InstCount=0 immediately, with no waiting for a clock edge.
REQ-034 InstCount preloaded by running to 0xFFFFFFFF, then Opcode=2 -> JUMP with PCWrite=1 and PCSource=10, and InstCount wraps to 0.
